// File: rtl/mult8x8_ctrl_if.sv
// mult8x8_ctrl_if: handshake and datapath-control bundle between the multiplier sequencer and its datapath.
interface mult8x8_ctrl_if;
  logic start;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic clk_ena;
  logic sclr_n;
  logic busy;
  logic done_flag;
  logic [2:0] state_out;
  modport master(input start, output input_sel, shift_sel, clk_ena, sclr_n, busy, done_flag, state_out);
  modport slave(output start, input input_sel, shift_sel, clk_ena, sclr_n, busy, done_flag, state_out);
endinterface

// File: rtl/mult8x8_ctrl.sv
// mult8x8_ctrl: sequences four nibble partial products into the 16-bit accumulator of an 8x8 multiplier.
module mult8x8_ctrl #(
  parameter bit DONE_STICKY = 1'b1
) (
  input logic clk,
  input logic reset_a,
  mult8x8_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, LSB = 3'd1, MID = 3'd2, MSB = 3'd3, CALC_DONE = 3'd4, ERR = 3'd5} state_t;
  state_t state;
  logic [1:0] count;
  logic done;
  logic accept;
  logic busy;
  assign accept = (state == IDLE || state == CALC_DONE) && bus.start;
  assign busy = state == LSB || state == MID || state == MSB;
  always_ff @(posedge clk or negedge reset_a)
    if (!reset_a) begin
      state <= IDLE;
      count <= 2'd0;
      done <= 1'b0;
    end else begin
      count <= accept ? 2'd0 : busy ? count + 2'd1 : count;
      done <= (state == MSB && !bus.start) || (DONE_STICKY && done && !bus.start);
      case (state)
        IDLE, CALC_DONE: state <= bus.start ? LSB : state;
        LSB:             state <= bus.start ? ERR : MID;
        MID:             state <= bus.start ? ERR : count == 2'd2 ? MSB : MID;
        MSB:             state <= bus.start ? ERR : CALC_DONE;
        ERR:             state <= bus.start ? ERR : IDLE;
        default:         state <= IDLE;
      endcase
    end
  // start is live during reset, so the Mealy outputs are masked by reset_a directly
  assign bus.clk_ena = reset_a && (accept || busy);
  assign bus.sclr_n = !(reset_a && accept);
  assign bus.shift_sel = state == MID ? 2'd1 : state == MSB ? 2'd2 : 2'd0;
  assign bus.input_sel = busy ? count : 2'd0;
  assign bus.busy = busy;
  assign bus.done_flag = done;
  assign bus.state_out = state;
endmodule

// File: tb/tb_mult8x8_ctrl.sv
// tb_mult8x8_ctrl: table-driven check of the sequencer with a behavioural nibble datapath attached.
module tb_mult8x8_ctrl;
  typedef struct {
    logic st;
    logic [2:0] state;
    logic [1:0] isel;
    logic [1:0] ssel;
    logic ena;
    logic sclr;
    logic busy;
    logic done1;
    logic done0;
  } row_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;
  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic start = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [15:0] acc = 16'd0;
  logic [7:0] pp;
  int checks = 0;
  int errors = 0;
  row_t rows[6];
  row_t acc_idle, acc_done, idle_row, err_rows[6];
  vec_t vecs[5];
  mult8x8_ctrl_if b1();
  mult8x8_ctrl_if b0();
  assign b1.start = start;
  assign b0.start = start;
  mult8x8_ctrl #(.DONE_STICKY(1'b1)) dut1 (.clk(clk), .reset_a(reset_a), .bus(b1));
  mult8x8_ctrl #(.DONE_STICKY(1'b0)) dut0 (.clk(clk), .reset_a(reset_a), .bus(b0));
  always #5 clk = ~clk;
  // reference datapath: 4x4 multiplier, shifter and clear-able accumulator
  assign pp = (b1.input_sel[1] ? a[7:4] : a[3:0]) * (b1.input_sel[0] ? b[7:4] : b[3:0]);
  always @(posedge clk)
    if (b1.clk_ena) acc <= !b1.sclr_n ? 16'd0 : acc + ({8'd0, pp} << {b1.shift_sel, 2'b00});
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input row_t r, input string tag);
    @(negedge clk);
    start = r.st;
    #1;
    chk({tag, " state"}, 16'(b1.state_out), 16'(r.state));
    chk({tag, " input_sel"}, 16'(b1.input_sel), 16'(r.isel));
    chk({tag, " shift_sel"}, 16'(b1.shift_sel), 16'(r.ssel));
    chk({tag, " clk_ena"}, 16'(b1.clk_ena), 16'(r.ena));
    chk({tag, " sclr_n"}, 16'(b1.sclr_n), 16'(r.sclr));
    chk({tag, " busy"}, 16'(b1.busy), 16'(r.busy));
    chk({tag, " done sticky"}, 16'(b1.done_flag), 16'(r.done1));
    chk({tag, " done pulse"}, 16'(b0.done_flag), 16'(r.done0));
    chk({tag, " state pulse"}, 16'(b0.state_out), 16'(r.state));
  endtask
  task automatic run(input vec_t v, input row_t first, input string tag);
    a = v.a;
    b = v.b;
    step(first, {tag, " accept"});
    for (int i = 0; i < 6; i++) step(rows[i], $sformatf("%s c%0d", tag, i + 1));
    chk({tag, " product"}, acc, v.p);
  endtask
  task automatic reset_now(input string tag);
    @(negedge clk);
    #2 reset_a = 1'b0;
    #1;
    chk({tag, " state"}, 16'(b1.state_out), 16'd0);
    chk({tag, " clk_ena"}, 16'(b1.clk_ena), 16'd0);
    chk({tag, " sclr_n"}, 16'(b1.sclr_n), 16'd1);
    chk({tag, " done"}, 16'(b1.done_flag), 16'd0);
    chk({tag, " busy"}, 16'(b1.busy), 16'd0);
    chk({tag, " input_sel"}, 16'(b1.input_sel), 16'd0);
    chk({tag, " shift_sel"}, 16'(b1.shift_sel), 16'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_a = 1'b1;
  endtask
  initial begin
    rows[0] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
    rows[1] = '{0, 2, 1, 1, 1, 1, 1, 0, 0};
    rows[2] = '{0, 2, 2, 1, 1, 1, 1, 0, 0};
    rows[3] = '{0, 3, 3, 2, 1, 1, 1, 0, 0};
    rows[4] = '{0, 4, 0, 0, 0, 1, 0, 1, 1};
    rows[5] = '{0, 4, 0, 0, 0, 1, 0, 1, 0};
    acc_idle = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    acc_done = '{1, 4, 0, 0, 1, 0, 0, 1, 0};
    idle_row = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    err_rows[0] = '{1, 4, 0, 0, 1, 0, 0, 1, 0};
    err_rows[1] = '{1, 1, 0, 0, 1, 1, 1, 0, 0};
    err_rows[2] = '{1, 5, 0, 0, 0, 1, 0, 0, 0};
    err_rows[3] = '{1, 5, 0, 0, 0, 1, 0, 0, 0};
    err_rows[4] = '{0, 5, 0, 0, 0, 1, 0, 0, 0};
    err_rows[5] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h12, 8'h34, 16'h03A8};
    vecs[2] = '{8'h00, 8'hAB, 16'h0000};
    vecs[3] = '{8'h0F, 8'hF0, 16'h0E10};
    vecs[4] = '{8'h80, 8'h02, 16'h0100};
    #1;
    chk("reset state", 16'(b1.state_out), 16'd0);
    chk("reset clk_ena", 16'(b1.clk_ena), 16'd0);
    chk("reset done", 16'(b1.done_flag), 16'd0);
    repeat (2) @(negedge clk);
    reset_a = 1'b1;
    run(vecs[0], acc_idle, "ffxff");
    for (int i = 1; i < 5; i++) run(vecs[i], acc_done, $sformatf("b2b%0d", i));
    a = 8'h37;
    b = 8'h25;
    for (int i = 0; i < 6; i++) step(err_rows[i], $sformatf("err%0d", i));
    chk("err partial acc", acc, 16'h0023);
    for (int i = 0; i < 20; i++) step(idle_row, $sformatf("idle%0d", i));
    chk("idle acc held", acc, 16'h0023);
    a = 8'h12;
    b = 8'h34;
    step(acc_idle, "rst_mid accept");
    step(rows[0], "rst_mid c1");
    step(rows[1], "rst_mid c2");
    reset_now("rst_mid");
    run(vecs[3], acc_idle, "post_rst");
    reset_now("rst_done");
    run(vecs[1], acc_idle, "final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
